// File: rtl/ifetch.sv
// Instruction fetch unit: zero-latency imem interface feeding a small prefetch FIFO whose head is the decode stage.
// Optional IFETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect instead of forcing word alignment.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        misalign
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(BUF_DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(1'b0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state_r;
  logic [31:0]     fetch_pc_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [PW:0]     count_r;
  logic [31:0]     buf_pc_r    [BUF_DEPTH];
  logic [31:0]     buf_instr_r [BUF_DEPTH];
  logic [31:0]     instr_r;
  logic [31:0]     pc_r;
  logic            misalign_r;

  logic            req_s;
  logic            accept_s;
  logic            consume_s;
  logic            redirect_s;
  logic            push_s;
  logic            pop_s;
  logic            trap_s;
  logic [31:0]     target_s;
  logic [PW-1:0]   head_nx_s;
  logic [31:0]     nxt_instr_s;
  logic [31:0]     nxt_pc_s;

  // Request is gated by rst so nothing is presented while reset is held.
  assign req_s      = !rst && (state_r == FETCH) && (count_r < DEPTH_C);
  assign accept_s   = req_s && imem_ready;
  assign consume_s  = (count_r != CNT_ZERO) && !stall;
  assign redirect_s = consume_s && PCSrc;
  assign push_s     = accept_s && !redirect_s;
  assign pop_s      = consume_s && !redirect_s;
  assign head_nx_s  = head_r + PTR_ONE;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign target_s = PCTarget;
  assign trap_s   = redirect_s && (PCTarget[1:0] != 2'b00);
  assign misalign = misalign_r;
`else
  assign target_s = PCTarget & 32'hFFFF_FFFC;
  assign trap_s   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = (count_r != CNT_ZERO);
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign op          = instr_r[6:0];
  assign funct3      = instr_r[14:12];
  assign funct7      = instr_r[30];

  // Next head word: the entry behind the popped one, the word arriving into an empty slot, or hold.
  always_comb begin
    nxt_instr_s = instr_r;
    nxt_pc_s    = pc_r;
    if (redirect_s) begin
      nxt_instr_s = instr_r;
      nxt_pc_s    = pc_r;
    end else if (pop_s && (count_r > CNT_ONE)) begin
      nxt_instr_s = buf_instr_r[head_nx_s];
      nxt_pc_s    = buf_pc_r[head_nx_s];
    end else if (push_s && (count_r == (pop_s ? CNT_ONE : CNT_ZERO))) begin
      nxt_instr_s = imem_rdata;
      nxt_pc_s    = fetch_pc_r;
    end else begin
      nxt_instr_s = instr_r;
      nxt_pc_s    = pc_r;
    end
  end

  // Control state, fetch pointer, FIFO storage and registered head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FETCH;
      fetch_pc_r <= RESET_PC;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      instr_r    <= 32'h0000_0000;
      pc_r       <= 32'h0000_0000;
      misalign_r <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_r[i]    <= 32'h0000_0000;
        buf_instr_r[i] <= 32'h0000_0000;
      end
    end else begin
      // Memory answers on the accept edge, so no word is ever left in flight to drain.
      case (state_r)
        FETCH:   state_r <= trap_s ? HALT : FETCH;
        DRAIN:   state_r <= FETCH;
        HALT:    state_r <= HALT;
        default: state_r <= FETCH;
      endcase

      if (trap_s) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end

      if (redirect_s) begin
        fetch_pc_r <= target_s;
        head_r     <= PTR_ZERO;
        tail_r     <= PTR_ZERO;
        count_r    <= CNT_ZERO;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (push_s) begin
          buf_pc_r[tail_r]    <= fetch_pc_r;
          buf_instr_r[tail_r] <= imem_rdata;
          tail_r              <= tail_r + PTR_ONE;
        end else begin
          tail_r <= tail_r;
        end
        if (pop_s) begin
          head_r <= head_nx_s;
        end else begin
          head_r <= head_r;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end

      instr_r <= nxt_instr_s;
      pc_r    <= nxt_pc_s;
    end
  end

endmodule
